// File: rtl/vga_pattern_sequencer_if.sv
// Pixel-side signal bundle between the VGA timing/pattern generator and the
// pattern sequencer. master = timing side, slave = sequencer.
interface vga_pattern_sequencer_if;
  logic [9:0] iVGA_X;
  logic [9:0] iVGA_Y;
  logic       iKEY_n;
  logic       iAUTO;
  logic [1:0] oPattern;
  logic       oColor_SW;
  logic       oFrame_Start;
  logic       oBlank;

  modport master (
    output iVGA_X, iVGA_Y, iKEY_n, iAUTO,
    input  oPattern, oColor_SW, oFrame_Start, oBlank
  );

  modport slave (
    input  iVGA_X, iVGA_Y, iKEY_n, iAUTO,
    output oPattern, oColor_SW, oFrame_Start, oBlank
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer: steps the pattern index on a debounced key press
// (manual mode) or every FRAMES_PER_STEP frames (auto mode). Pattern changes
// only land on a frame start. Optional feature macro VGA_SEQ_BLANK_GAP_EN
// inserts one black frame before each pattern change.
module vga_pattern_sequencer #(
  parameter int unsigned NUM_PATTERNS    = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FRAMES_PER_STEP = 120
) (
  input logic                    iVGA_CLK,
  input logic                    iRST,
  vga_pattern_sequencer_if.slave vgaSeq
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FC_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [1:0]      PAT_LAST = 2'(NUM_PATTERNS - 1);

  typedef enum logic {
    S_MANUAL,
    S_AUTO
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [1:0]        keySync;
  logic [1:0]        autoSync;
  logic              keyStable;
  logic [DB_W-1:0]   dbCnt;
  logic              pressEvt;
  logic [9:0]        prevX;
  logic [9:0]        prevY;
  logic              frameTick;
  logic              pending;
  logic              pendingNext;
  logic [FC_W-1:0]   frameCnt;
  logic [FC_W-1:0]   frameCntNext;
  logic              stepReq;
  logic [1:0]        pattern;
  logic [1:0]        patNext;
  logic              frameStart;

  // Two-stage synchronizers for the asynchronous key and mode switch
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      keySync  <= '1;
      autoSync <= '0;
    end else begin
      keySync  <= {keySync[0], vgaSeq.iKEY_n};
      autoSync <= {autoSync[0], vgaSeq.iAUTO};
    end
  end

  // Debouncer: accept a new key level after DEBOUNCE_CYCLES disagreeing samples; pulse on press
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      keyStable <= 1'b1;
      dbCnt     <= '0;
      pressEvt  <= 1'b0;
    end else begin
      pressEvt <= 1'b0;
      if (keySync[1] != keyStable) begin
        if (dbCnt == DB_LAST) begin
          keyStable <= keySync[1];
          dbCnt     <= '0;
          pressEvt  <= ~keySync[1];
        end else begin
          dbCnt <= dbCnt + 1'b1;
        end
      end else begin
        dbCnt <= '0;
      end
    end
  end

  // Previous pixel coordinate for frame-start edge detection
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      prevX <= '0;
      prevY <= '0;
    end else begin
      prevX <= vgaSeq.iVGA_X;
      prevY <= vgaSeq.iVGA_Y;
    end
  end

  // Frame start: origin presented now, something else presented last cycle
  always_comb begin
    frameTick = (vgaSeq.iVGA_X == '0) && (vgaSeq.iVGA_Y == '0) &&
                ((prevX != '0) || (prevY != '0));
  end

  // Mode state register
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state <= S_MANUAL;
    end else begin
      state <= nextState;
    end
  end

  // Next mode, step request, pending flag and auto frame counter
  always_comb begin
    nextState    = state;
    stepReq      = 1'b0;
    pendingNext  = pending;
    frameCntNext = frameCnt;
    unique case (state)
      S_MANUAL: begin
        // counter held at zero so it starts clean on entry to auto
        frameCntNext = '0;
        if (frameTick) begin
          stepReq     = pending | pressEvt;
          pendingNext = 1'b0;
        end else if (pressEvt) begin
          pendingNext = 1'b1;
        end
        if (autoSync[1]) begin
          nextState = S_AUTO;
        end
      end
      S_AUTO: begin
        pendingNext = 1'b0;
        if (frameTick) begin
          if (frameCnt == FC_LAST) begin
            stepReq      = 1'b1;
            frameCntNext = '0;
          end else begin
            frameCntNext = frameCnt + 1'b1;
          end
        end
        if (!autoSync[1]) begin
          nextState = S_MANUAL;
        end
      end
      default: nextState = S_MANUAL;
    endcase
  end

  // Pending flag, frame counter and frame-start pulse registers
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      pending    <= 1'b0;
      frameCnt   <= '0;
      frameStart <= 1'b0;
    end else begin
      pending    <= pendingNext;
      frameCnt   <= frameCntNext;
      frameStart <= frameTick;
    end
  end

  // Wrapping increment; with a single pattern this stays at 0
  always_comb begin
    patNext = (pattern == PAT_LAST) ? 2'd0 : pattern + 2'd1;
  end

`ifdef VGA_SEQ_BLANK_GAP_EN
  logic blankGap;

  // A step first blanks one whole frame; the index advances when the blank frame ends
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      pattern  <= '0;
      blankGap <= 1'b0;
    end else if (frameTick) begin
      if (blankGap) begin
        blankGap <= 1'b0;
        pattern  <= patNext;
      end else if (stepReq) begin
        blankGap <= 1'b1;
      end
    end
  end

  assign vgaSeq.oBlank = blankGap;
`else
  // Step applies directly at the frame start that carries the request
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      pattern <= '0;
    end else if (stepReq) begin
      pattern <= patNext;
    end
  end

  assign vgaSeq.oBlank = 1'b0;
`endif

  assign vgaSeq.oPattern     = pattern;
  assign vgaSeq.oColor_SW    = pattern[0];
  assign vgaSeq.oFrame_Start = frameStart;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer on a tiny 8x4 raster. A behavioural model
// tracks the expected outputs every pixel clock; directed phases add fixed
// checkpoints, then a randomized phase exercises key/mode/reset mixes.
module tb_vga_pattern_sequencer;

  localparam int unsigned NUM_PAT = 3;
  localparam int unsigned DEB     = 4;
  localparam int unsigned FPS     = 3;

  logic clk = 1'b0;
  logic rst;

  vga_pattern_sequencer_if seqIf ();

  vga_pattern_sequencer #(
    .NUM_PATTERNS   (NUM_PAT),
    .DEBOUNCE_CYCLES(DEB),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .iVGA_CLK(clk),
    .iRST    (rst),
    .vgaSeq  (seqIf)
  );

  always #5 clk = ~clk;

  int unsigned vecCount  = 0;
  int unsigned missCount = 0;
  int unsigned curX;
  int unsigned curY;

  // Reference model state
  bit [1:0]    mKeyDelay;
  bit [1:0]    mAutoDelay;
  bit          mStable;
  int unsigned mRun;
  bit          mPress;
  bit          mAuto;
  int unsigned mTicks;
  bit          mPending;
  int unsigned mPat;
  bit          mBlank;
  bit          mFs;
  logic [19:0] mPrevXY;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one rising edge, computed from the behavioural rules
  function automatic void modelEdge();
    bit          tick;
    bit          keySynced;
    bit          autoSynced;
    bit          stepReq;
    bit          newPress;
    logic [19:0] xy;
    if (rst) begin
      mKeyDelay  = 2'b11;
      mAutoDelay = 2'b00;
      mStable    = 1'b1;
      mRun       = 0;
      mPress     = 1'b0;
      mAuto      = 1'b0;
      mTicks     = 0;
      mPending   = 1'b0;
      mPat       = 0;
      mBlank     = 1'b0;
      mFs        = 1'b0;
      mPrevXY    = '0;
      return;
    end
    xy         = {seqIf.iVGA_Y, seqIf.iVGA_X};
    tick       = (xy == 20'd0) && (mPrevXY != 20'd0);
    keySynced  = mKeyDelay[1];
    autoSynced = mAutoDelay[1];
    stepReq    = 1'b0;
    newPress   = 1'b0;

    if (mAuto) begin
      mPending = 1'b0;
      if (tick) begin
        mTicks++;
        stepReq = (mTicks % FPS) == 0;
      end
    end else begin
      mTicks = 0;
      if (tick) begin
        stepReq  = mPending || mPress;
        mPending = 1'b0;
      end else if (mPress) begin
        mPending = 1'b1;
      end
    end

`ifdef VGA_SEQ_BLANK_GAP_EN
    if (tick) begin
      if (mBlank) begin
        mBlank = 1'b0;
        mPat   = (mPat + 1) % NUM_PAT;
      end else if (stepReq) begin
        mBlank = 1'b1;
      end
    end
`else
    if (stepReq) mPat = (mPat + 1) % NUM_PAT;
`endif

    if (keySynced != mStable) begin
      mRun++;
      if (mRun == DEB) begin
        mStable  = keySynced;
        mRun     = 0;
        newPress = !keySynced;
      end
    end else begin
      mRun = 0;
    end
    mPress     = newPress;
    mAuto      = autoSynced;
    mKeyDelay  = {mKeyDelay[0], seqIf.iKEY_n};
    mAutoDelay = {mAutoDelay[0], seqIf.iAUTO};
    mFs        = tick;
    mPrevXY    = xy;
  endfunction

  task automatic compareAll();
    checkVal("oPattern", seqIf.oPattern, mPat);
    checkVal("oColor_SW", seqIf.oColor_SW, mPat % 2);
    checkVal("oFrame_Start", seqIf.oFrame_Start, mFs);
    checkVal("oBlank", seqIf.oBlank, mBlank);
  endtask

  // One pixel clock: model the edge, check after it, then present the next pixel
  task automatic pixelClock();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
    if (curX == 7) begin
      curX = 0;
      curY = (curY == 3) ? 0 : curY + 1;
    end else begin
      curX++;
    end
    seqIf.iVGA_X = 10'(curX);
    seqIf.iVGA_Y = 10'(curY);
  endtask

  task automatic runN(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pixelClock();
  endtask

  // Advance until the origin is being presented (not yet clocked)
  task automatic runToOrigin();
    for (int unsigned i = 0; i < 40; i++) begin
      if (curX == 0 && curY == 0) break;
      pixelClock();
    end
  endtask

  initial begin
    int unsigned fsCount;
    int unsigned changes;
    logic [1:0]  lastPat;
    int unsigned keyHold;
    int unsigned autoHold;

    rst          = 1'b1;
    seqIf.iKEY_n = 1'b1;
    seqIf.iAUTO  = 1'b0;
    curX         = 3;
    curY         = 1;
    seqIf.iVGA_X = 10'(curX);
    seqIf.iVGA_Y = 10'(curY);

    // Reset and two idle frames
    runN(3);
    rst = 1'b0;
    checkVal("rst_pattern", seqIf.oPattern, 0);
    checkVal("rst_blank", seqIf.oBlank, 0);
    checkVal("rst_frame_start", seqIf.oFrame_Start, 0);
    fsCount = 0;
    for (int i = 0; i < 64; i++) begin
      pixelClock();
      if (seqIf.oFrame_Start) fsCount++;
    end
    checkVal("idle_frame_starts", fsCount, 2);
    checkVal("idle_pattern", seqIf.oPattern, 0);

`ifdef VGA_SEQ_BLANK_GAP_EN
    // Press -> one blank frame with old pattern, then new pattern
    seqIf.iKEY_n = 1'b0;
    runN(8);
    seqIf.iKEY_n = 1'b1;
    runN(6);
    runToOrigin();
    pixelClock();
    checkVal("blank_start", seqIf.oBlank, 1);
    checkVal("blank_pattern_held", seqIf.oPattern, 0);
    runN(31);
    checkVal("blank_whole_frame", seqIf.oBlank, 1);
    pixelClock();
    checkVal("blank_end", seqIf.oBlank, 0);
    checkVal("blank_advance", seqIf.oPattern, 1);
`else
    // Short bounce is rejected
    seqIf.iKEY_n = 1'b0;
    runN(3);
    seqIf.iKEY_n = 1'b1;
    runN(10);
    runToOrigin();
    pixelClock();
    checkVal("bounce_no_step", seqIf.oPattern, 0);

    // Long press mid-frame steps only at the next frame start
    runN(4);
    seqIf.iKEY_n = 1'b0;
    runN(10);
    seqIf.iKEY_n = 1'b1;
    runN(8);
    runToOrigin();
    checkVal("press_not_early", seqIf.oPattern, 0);
    pixelClock();
    checkVal("press_at_tick", seqIf.oPattern, 1);

    // Two presses in one frame give a single step
    seqIf.iKEY_n = 1'b0;
    runN(8);
    seqIf.iKEY_n = 1'b1;
    runN(8);
    seqIf.iKEY_n = 1'b0;
    runN(8);
    seqIf.iKEY_n = 1'b1;
    runToOrigin();
    pixelClock();
    checkVal("double_press_one_step", seqIf.oPattern, 2);

    // Auto mode for 9 frames: three steps, presses ignored
    seqIf.iAUTO = 1'b1;
    changes     = 0;
    lastPat     = seqIf.oPattern;
    for (int i = 0; i < 288; i++) begin
      if (i < 250 && (i % 5) == 0) seqIf.iKEY_n = 1'($urandom_range(0, 1));
      if (i == 250) seqIf.iKEY_n = 1'b1;
      pixelClock();
      if (seqIf.oPattern != lastPat) changes++;
      lastPat = seqIf.oPattern;
    end
    checkVal("auto_step_count", changes, 3);
    checkVal("auto_final", seqIf.oPattern, 2);
    seqIf.iAUTO = 1'b0;
    runN(4);

    // Press event lands exactly on the frame-start cycle
    runToOrigin();
    pixelClock();
    runN(25);
    seqIf.iKEY_n = 1'b0;
    runN(6);
    checkVal("coinc_before", seqIf.oPattern, 2);
    pixelClock();
    checkVal("coinc_step_wrap", seqIf.oPattern, 0);
    seqIf.iKEY_n = 1'b1;
    runN(10);

    // Reset mid-frame with a press pending discards it
    seqIf.iKEY_n = 1'b0;
    runN(8);
    seqIf.iKEY_n = 1'b1;
    runN(10);
    runToOrigin();
    pixelClock();
    checkVal("pre_rst_step", seqIf.oPattern, 1);
    runN(3);
    seqIf.iKEY_n = 1'b0;
    runN(8);
    seqIf.iKEY_n = 1'b1;
    runN(4);
    rst = 1'b1;
    runN(2);
    rst = 1'b0;
    checkVal("rst_clears_pattern", seqIf.oPattern, 0);
    runToOrigin();
    pixelClock();
    checkVal("rst_drops_pending", seqIf.oPattern, 0);
`endif

    // Randomized key, mode and occasional reset
    keyHold  = 0;
    autoHold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (keyHold == 0) begin
        seqIf.iKEY_n = 1'($urandom_range(0, 1));
        keyHold      = $urandom_range(1, 12);
      end else begin
        keyHold--;
      end
      if (autoHold == 0) begin
        seqIf.iAUTO = ($urandom_range(0, 3) == 0);
        autoHold    = $urandom_range(32, 320);
      end else begin
        autoHold--;
      end
      rst = ($urandom_range(0, 699) == 0);
      pixelClock();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
